// File: rtl/lovelace_pkg.sv
// rtl/lovelace_pkg.sv - shared FSM encoding, ASCII and component constants for the command parser
package lovelace_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ID   = 3'd1,
        S_GET_IDX  = 3'd2,
        S_GET_VAL  = 3'd3,
        S_EMIT     = 3'd4,
        S_SKIP     = 3'd5,
        S_LINE_END = 3'd6
    } state_t;

    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_1  = 8'h31;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_B  = 8'h62;
    localparam logic [7:0] CH_F  = 8'h66;
    localparam logic [7:0] CH_T  = 8'h74;
    localparam logic [7:0] CH_H  = 8'h68;
    localparam logic [7:0] CH_E  = 8'h65;

    localparam logic [1:0] AIRFLOW_ID   = 2'b00;
    localparam logic [1:0] THRUSTERS_ID = 2'b01;
    localparam logic [1:0] SOLAR_ID     = 2'b10;

    localparam logic RADIX_BIN = 1'b0;
    localparam logic RADIX_DEC = 1'b1;

endpackage

// File: rtl/cmd_digit_decode.sv
// rtl/cmd_digit_decode.sv - classifies an ASCII byte as a binary or decimal digit
import lovelace_pkg::*;

module cmd_digit_decode (
    input  logic [7:0] in_byte,
    input  logic       radix,
    output logic       is_digit,
    output logic [3:0] digit
);

    // ASCII '0'..'9' sit at 0x30..0x39, so the low nibble is already the value
    always_comb begin
        digit = in_byte[3:0];
        if (radix == RADIX_DEC)
            is_digit = (in_byte >= CH_0) && (in_byte <= CH_9);
        else
            is_digit = (in_byte == CH_0) || (in_byte == CH_1);
    end

endmodule

// File: rtl/cmd_parser.sv
// rtl/cmd_parser.sv - ASCII command-line parser; PARSE_ERR_CNT_EN adds a saturating err_cnt cleared by "e\n"
import lovelace_pkg::*;

module cmd_parser #(
    parameter int IDX_W = 8,
    parameter int VAL_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             cmd_float,
    output logic [1:0]       cmd_id,
    output logic [IDX_W-1:0] cmd_index,
    output logic [VAL_W-1:0] cmd_value,
    output logic             tick,
    output logic             parse_err
`ifdef PARSE_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    state_t     state;
    logic       got_digit;
    logic       val_done;
    logic       radix;
    logic       is_digit;
    logic [3:0] digit;
`ifdef PARSE_ERR_CNT_EN
    logic       line_clear;
`endif

    assign radix     = (state == S_GET_IDX || (state == S_GET_VAL && cmd_float)) ? RADIX_DEC : RADIX_BIN;
    assign in_ready  = (state != S_EMIT);
    assign cmd_valid = (state == S_EMIT);

    cmd_digit_decode u_digit (
        .in_byte  (in_byte),
        .radix    (radix),
        .is_digit (is_digit),
        .digit    (digit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cmd_float <= 1'b0;
            cmd_id    <= '0;
            cmd_index <= '0;
            cmd_value <= '0;
            tick      <= 1'b0;
            parse_err <= 1'b0;
            got_digit <= 1'b0;
            val_done  <= 1'b0;
`ifdef PARSE_ERR_CNT_EN
            line_clear <= 1'b0;
            err_cnt    <= '0;
`endif
        end else begin
            parse_err <= 1'b0;
`ifdef PARSE_ERR_CNT_EN
            if (parse_err && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
`endif
            if (state == S_EMIT) begin
                if (cmd_ready)
                    state <= S_IDLE;
            end else if (in_valid) begin
                case (state)
                    S_IDLE: begin
                        if (in_byte == CH_B || in_byte == CH_F) begin
                            state     <= S_GET_ID;
                            cmd_float <= (in_byte == CH_F);
                            cmd_id    <= '0;
                            cmd_index <= '0;
                            cmd_value <= '0;
                            got_digit <= 1'b0;
                            val_done  <= 1'b0;
                        end else if (in_byte == CH_T) begin
`ifdef PARSE_ERR_CNT_EN
                            line_clear <= 1'b0;
`endif
                            state <= S_LINE_END;
`ifdef PARSE_ERR_CNT_EN
                        end else if (in_byte == CH_E) begin
                            line_clear <= 1'b1;
                            state      <= S_LINE_END;
`endif
                        end else if (in_byte == CH_H) begin
                            state <= S_SKIP;
                        end else if (in_byte != CH_LF && in_byte != CH_CR) begin
                            parse_err <= 1'b1;
                            state     <= S_SKIP;
                        end
                    end
                    // single-letter lines commit only on their '\n'; trailing junk is malformed
                    S_LINE_END: begin
                        if (in_byte == CH_LF) begin
`ifdef PARSE_ERR_CNT_EN
                            if (line_clear)
                                err_cnt <= '0;
                            else
                                tick <= ~tick;
`else
                            tick <= ~tick;
`endif
                            state <= S_IDLE;
                        end else if (in_byte != CH_CR) begin
                            parse_err <= 1'b1;
                            state     <= S_SKIP;
                        end
                    end
                    S_GET_ID, S_GET_IDX, S_GET_VAL: begin
                        if (in_byte == CH_SP) begin
                            if (got_digit) begin
                                got_digit <= 1'b0;
                                if (state == S_GET_ID)
                                    state <= S_GET_IDX;
                                else if (state == S_GET_IDX)
                                    state <= S_GET_VAL;
                                else
                                    val_done <= 1'b1;
                            end
                        end else if (in_byte == CH_LF) begin
                            if (state == S_GET_VAL && (got_digit || val_done)) begin
                                state <= S_EMIT;
                            end else begin
                                parse_err <= 1'b1;
                                state     <= S_IDLE;
                            end
                        end else if (in_byte != CH_CR) begin
                            if (is_digit && !val_done) begin
                                got_digit <= 1'b1;
                                if (state == S_GET_ID)
                                    cmd_id <= {cmd_id[0], digit[0]};
                                else if (state == S_GET_IDX)
                                    cmd_index <= cmd_index * IDX_W'(10) + IDX_W'(digit);
                                else if (cmd_float)
                                    cmd_value <= cmd_value * VAL_W'(10) + VAL_W'(digit);
                                else
                                    cmd_value <= {cmd_value[VAL_W-2:0], digit[0]};
                            end else begin
                                parse_err <= 1'b1;
                                state     <= S_SKIP;
                            end
                        end
                    end
                    S_SKIP: begin
                        if (in_byte == CH_LF)
                            state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
